// File: rtl/instr_encoder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : instr_encoder_if                                   |
// | Description : Instruction-beat input handshake plus instruction  |
// |               memory write port of the instruction encoder.      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
interface instr_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic              last_i;
  logic [3:0]        op_sel_i;
  logic [4:0]        rs_i;
  logic [4:0]        rt_i;
  logic [4:0]        rd_i;
  logic [15:0]       imm_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic              mem_ready_i;

  // Program source and instruction memory side
  modport master (
    output in_valid_i, last_i, op_sel_i, rs_i, rt_i, rd_i, imm_i, mem_ready_i,
    input  in_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );

  // Encoder side
  modport slave (
    input  in_valid_i, last_i, op_sel_i, rs_i, rt_i, rd_i, imm_i, mem_ready_i,
    output in_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : instr_encoder                                      |
// | Description : Packs symbolic instructions into 32-bit MIPS words, |
// |               buffers them in a FIFO and writes them to          |
// |               instruction memory at auto-incrementing addresses. |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clear_i,
  instr_encoder_if.slave bus,
  output logic           done_o,
  output logic           err_o,
  output logic [7:0]     err_cnt_o
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_done;
  logic               r_err;
  logic [7:0]         r_err_cnt;

  logic               w_full;
  logic               w_empty;
  logic               w_ready;
  logic               w_accept;
  logic               w_illegal;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_word;
  logic [c_CNT_W-1:0] w_count_next;

  assign w_full       = (r_count == c_CNT_W'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_ready      = (r_state != S_DRAIN) && !w_full;
  assign w_accept     = bus.in_valid_i && w_ready;
  assign w_push       = w_accept && !w_illegal;
  assign w_pop        = !w_empty && bus.mem_ready_i;
  assign w_count_next = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

  assign bus.in_ready_o = w_ready;
  assign bus.mem_we_o   = !w_empty;
  assign bus.mem_addr_o = r_addr;
  // Empty FIFO presents zero so the data bus has a defined idle value
  assign bus.mem_data_o = w_empty ? 32'd0 : r_mem[r_rd_ptr];
  assign done_o         = r_done;
  assign err_o          = r_err;
  assign err_cnt_o      = r_err_cnt;

  // Combinational field packing; lui drops rs, I-types drop rd, R-types drop imm
  always_comb begin
    w_word    = 32'd0;
    w_illegal = 1'b0;
    case (bus.op_sel_i)
      4'd0:    w_word = {6'h00, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h20};
      4'd1:    w_word = {6'h00, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h22};
      4'd2:    w_word = {6'h00, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h24};
      4'd3:    w_word = {6'h00, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h25};
      4'd4:    w_word = {6'h00, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h2A};
      4'd5:    w_word = {6'h08, bus.rs_i, bus.rt_i, bus.imm_i};
      4'd6:    w_word = {6'h0A, bus.rs_i, bus.rt_i, bus.imm_i};
      4'd7:    w_word = {6'h04, bus.rs_i, bus.rt_i, bus.imm_i};
      4'd8:    w_word = {6'h05, bus.rs_i, bus.rt_i, bus.imm_i};
      4'd9:    w_word = {6'h0F, 5'd0,     bus.rt_i, bus.imm_i};
      4'd10:   w_word = {6'h0D, bus.rs_i, bus.rt_i, bus.imm_i};
      default: w_illegal = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset because the count gates visibility
  always_ff @(posedge clk_i) begin
    if (w_push && !clear_i) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // FIFO pointers, occupancy and write address; clear overrides push and pop
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= BASE_ADDR;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= BASE_ADDR;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        // Address wraps modulo 2^ADDR_W, not back to BASE_ADDR
        r_addr   <= r_addr + ADDR_W'(4);
      end
      r_count <= w_count_next;
    end
  end

  // Program state machine with registered done/error pulses and error counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else if (clear_i) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_accept && w_illegal;
      if (w_accept && w_illegal && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= bus.last_i ? S_DRAIN : S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept && bus.last_i) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_count_next == '0) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
